// File: rtl/trng_pkg.sv
// Shared constants for the TRNG byte source and its helpers.
package trng_pkg;
    localparam int SAMPLE_DIV_DEF = 16;
    localparam int RCT_LIMIT_DEF  = 32;
    localparam int BYTE_W         = 8;
    localparam int IDX_W          = 3;
endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann pair debiaser: 01 -> 0, 10 -> 1, 00/11 -> nothing.
module trng_vn_debias
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    input  logic s,
    output logic bit_valid,
    output logic bit_out
);
    logic have_q, have_d;
    logic first_q, first_d;

    always_comb begin
        have_d    = have_q;
        first_d   = first_q;
        bit_valid = 1'b0;
        bit_out   = first_q;
        if (clr) begin
            have_d = 1'b0;
        end else if (tick) begin
            if (!have_q) begin
                have_d  = 1'b1;
                first_d = s;
            end else begin
                have_d    = 1'b0;
                bit_valid = (first_q != s);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            have_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            have_q  <= have_d;
            first_q <= first_d;
        end
    end
endmodule

// File: rtl/trng_uart_ctrl.sv
// TRNG byte source: ring-oscillator sampler with repetition-count health test,
// optional von Neumann debiasing and a valid/ready byte output.
module trng_uart_ctrl
    import trng_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int RCT_LIMIT  = RCT_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              vn_en,
    input  logic              rnd_in,
    input  logic              fault_clr,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              fault
);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int RUN_W = $clog2(RCT_LIMIT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RCT_LIMIT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTE_W - 1);

    logic              sync1_q, sync2_q;
    logic [DIV_W-1:0]  div_q;
    logic              tick;
    logic              prev_q, fault_q;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              vn_en_q, vn_clr, vn_bit_valid, vn_bit;
    logic              emit_valid, emit_bit;
    logic [BYTE_W-1:0] sh_q, hold_q;
    logic [IDX_W-1:0]  cnt_q;
    logic              full_q, hold_vld_q, load;

    assign tick = en && (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            div_q   <= '0;
            vn_en_q <= 1'b0;
        end else begin
            sync1_q <= rnd_in;
            sync2_q <= sync1_q;
            vn_en_q <= vn_en;
            if (!en || tick) div_q <= '0;
            else             div_q <= div_q + 1'b1;
        end
    end

    always_comb begin
        run_d = run_q;
        if (sync2_q != prev_q)    run_d = RUN_W'(1);
        else if (run_q != RUN_MAX) run_d = run_q + 1'b1;
    end

    // A clear coinciding with a tick wins; that sample is not evaluated.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            run_q   <= '0;
            fault_q <= 1'b0;
        end else if (fault_clr) begin
            run_q   <= '0;
            fault_q <= 1'b0;
        end else if (tick) begin
            prev_q <= sync2_q;
            run_q  <= run_d;
            if (run_d == RUN_MAX) fault_q <= 1'b1;
        end
    end

    assign vn_clr = !en || (vn_en != vn_en_q) || fault_q;

    trng_vn_debias u_vn (
        .clk       (clk),
        .rst       (rst),
        .clr       (vn_clr),
        .tick      (tick && vn_en),
        .s         (sync2_q),
        .bit_valid (vn_bit_valid),
        .bit_out   (vn_bit)
    );

    assign emit_valid = !fault_q && (vn_en ? vn_bit_valid : tick);
    assign emit_bit   = vn_en ? vn_bit : sync2_q;
    assign load       = full_q && (!hold_vld_q || tx_ready);

    always_ff @(posedge clk) begin
        if (rst || fault_q) begin
            sh_q       <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else if (load) begin
            hold_q     <= sh_q;
            hold_vld_q <= 1'b1;
            sh_q       <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
        end else begin
            if (hold_vld_q && tx_ready) hold_vld_q <= 1'b0;
            if (emit_valid && !full_q) begin
                sh_q[cnt_q] <= emit_bit;
                cnt_q       <= cnt_q + 1'b1;
                if (cnt_q == IDX_LAST) full_q <= 1'b1;
            end
        end
    end

    assign tx_data  = hold_q;
    assign tx_valid = hold_vld_q;
    assign fault    = fault_q;
endmodule

// File: tb/tb_trng_uart_ctrl.sv
// Scenario bench for trng_uart_ctrl against a sample-list reference model.
module tb_trng_uart_ctrl;
    localparam int DIV = 4;
    localparam int LIM = 32;

    logic       clk = 1'b0;
    logic       rst, en, vn_en, rnd_in, fault_clr, tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, fault;

    int errors = 0;
    int checks = 0;
    int unstable_n = 0;
    bit rdy_rand = 1'b0;

    bit         stim_q[$];
    bit         bit_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = 8'h00;

    trng_uart_ctrl #(.SAMPLE_DIV(DIV), .RCT_LIMIT(LIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .vn_en     (vn_en),
        .rnd_in    (rnd_in),
        .fault_clr (fault_clr),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // Transfers and held-data stability observed mid-cycle.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
        if (!rst && pv && !pr && tx_valid && tx_data !== pd) unstable_n++;
        pv = tx_valid;
        pr = tx_ready;
        pd = tx_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_rand) tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; vn_en = 1'b0; rnd_in = 1'b0;
        fault_clr = 1'b0; tx_ready = 1'b0; rdy_rand = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        got_q.delete();
        bit_q.delete();
        unstable_n = 0;
    endtask

    // Must be entered right after en rises, reset releases, or a tick edge.
    task automatic run_stim();
        foreach (stim_q[i]) begin
            rnd_in = stim_q[i];
            repeat (DIV) step();
        end
    endtask

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic model_seg(input bit vn);
        if (!vn) begin
            foreach (stim_q[i]) bit_q.push_back(stim_q[i]);
        end else begin
            for (int i = 0; i + 1 < stim_q.size(); i += 2)
                if (stim_q[i] != stim_q[i+1]) bit_q.push_back(stim_q[i]);
        end
    endtask

    task automatic build_exp();
        exp_q.delete();
        for (int k = 0; (k + 1) * 8 <= bit_q.size(); k++) begin
            logic [7:0] b;
            b = 8'h00;
            for (int j = 0; j < 8; j++) b[j] = bit_q[8*k + j];
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < 300 && got_q.size() < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; vn_en = 1'b0; rnd_in = 1'b1;
        fault_clr = 1'b0; tx_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", tx_data); end
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", tx_valid); end
        checks++;
        if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
    endtask

    task automatic test_raw_latency();
        int first, second, k;
        logic [7:0] d1, d2;
        logic prev_v;
        do_reset();
        first = -1; second = -1; k = 0; d1 = 8'h00; d2 = 8'h00; prev_v = 1'b0;
        tx_ready = 1'b1;
        rnd_in = 1'b1;
        en = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            step();
            if (c % DIV == 0) begin
                k++;
                rnd_in = (k % 2 == 0);
            end
            if (tx_valid && !prev_v) begin
                if (first < 0) begin first = c; d1 = tx_data; end
                else if (second < 0) begin second = c; d2 = tx_data; end
            end
            prev_v = tx_valid;
        end
        en = 1'b0;
        // first tick after DIV edges, 7 more ticks to bit 7, one cycle to load
        checks++;
        if (first != 8*DIV + 1) begin errors++; $display("FAIL raw_latency: got %0d cycles expected %0d", first, 8*DIV + 1); end
        checks++;
        if (d1 !== 8'h55) begin errors++; $display("FAIL raw_byte0: got %h expected 55", d1); end
        checks++;
        if (second - first != 8*DIV) begin errors++; $display("FAIL raw_period: got %0d expected %0d", second - first, 8*DIV); end
        checks++;
        if (d2 !== 8'h55) begin errors++; $display("FAIL raw_byte1: got %h expected 55", d2); end
    endtask

    task automatic test_vn_pattern();
        do_reset();
        tx_ready = 1'b1;
        vn_en = 1'b1;
        stim_q.delete();
        for (int r = 0; r < 3; r++) begin
            stim_q.push_back(0); stim_q.push_back(1);
            stim_q.push_back(1); stim_q.push_back(0);
            stim_q.push_back(0); stim_q.push_back(0);
            stim_q.push_back(1); stim_q.push_back(1);
            stim_q.push_back(1); stim_q.push_back(0);
        end
        en = 1'b1;
        run_stim();
        en = 1'b0;
        model_seg(1'b1);
        build_exp();
        wait_drain(exp_q.size());
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL vn_pat_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL vn_pat_byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int m = 0; m < 2; m++) begin
            do_reset();
            vn_en = (m == 1);
            rdy_rand = 1'b1;
            fill_random(m == 0 ? 80 : 200);
            en = 1'b1;
            run_stim();
            en = 1'b0;
            model_seg(m == 1);
            build_exp();
            wait_drain(exp_q.size());
            rdy_rand = 1'b0;
            checks++;
            if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", m, got_q.size(), exp_q.size()); end
            foreach (exp_q[i]) begin
                checks++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_byte%0d: got %h expected %h", m, i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tx_ready = 1'b0;
        fill_random(1000 / DIV);
        en = 1'b1;
        run_stim();
        en = 1'b0;
        for (int i = 0; i < 16; i++) bit_q.push_back(stim_q[i]);
        build_exp();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin errors++; $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, exp_q[0]); end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL stall_no_xfer: got %0d transfers expected 0", got_q.size()); end
        checks++;
        if (unstable_n != 0) begin errors++; $display("FAIL stall_stable: got %0d data changes expected 0", unstable_n); end
        tx_ready = 1'b1;
        step();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp_q[1]) begin errors++; $display("FAIL stall_next: got valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, exp_q[1]); end
        step();
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL stall_empty: got valid=%b expected 0", tx_valid); end
        checks++;
        if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL stall_order: got %0d bytes, expected %h %h", got_q.size(), exp_q[0], exp_q[1]);
        end
    endtask

    task automatic test_fault();
        localparam int TRIP1 = LIM * DIV;
        localparam int CLR_C = TRIP1 + 20;
        localparam int TCLR  = ((CLR_C + 1) / DIV + 1) * DIV;
        localparam int TRIP2 = TCLR + (LIM - 1) * DIV;
        do_reset();
        rnd_in = 1'b1;
        tx_ready = 1'b0;
        en = 1'b1;
        for (int c = 1; c <= TRIP2 + 3; c++) begin
            step();
            if (c == TRIP1 - 1) begin
                checks++;
                if (fault !== 1'b0) begin errors++; $display("FAIL fault_early: got %b expected 0", fault); end
            end
            if (c == TRIP1) begin
                checks++;
                if (fault !== 1'b1) begin errors++; $display("FAIL fault_trip: got %b expected 1", fault); end
                checks++;
                if (tx_valid !== 1'b1) begin errors++; $display("FAIL fault_held: got valid=%b expected 1", tx_valid); end
            end
            if (c == TRIP1 + 1) begin
                checks++;
                if (tx_valid !== 1'b0) begin errors++; $display("FAIL fault_flush: got valid=%b expected 0", tx_valid); end
                tx_ready = 1'b1;
            end
            if (c == CLR_C) begin
                checks++;
                if (fault !== 1'b1 || got_q.size() != 0) begin errors++; $display("FAIL fault_quiet: got fault=%b bytes=%0d expected 1 and 0", fault, got_q.size()); end
                fault_clr = 1'b1;
            end
            if (c == CLR_C + 1) begin
                fault_clr = 1'b0;
                checks++;
                if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b expected 0", fault); end
            end
            if (c == TRIP2 - 1) begin
                checks++;
                if (fault !== 1'b0) begin errors++; $display("FAIL fault_early2: got %b expected 0", fault); end
            end
            if (c == TRIP2) begin
                checks++;
                if (fault !== 1'b1) begin errors++; $display("FAIL fault_trip2: got %b expected 1", fault); end
            end
        end
        en = 1'b0;
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL fault_bytes: got %0d expected 3", got_q.size()); end
        foreach (got_q[i]) begin
            checks++;
            if (got_q[i] !== 8'hFF) begin errors++; $display("FAIL fault_byte%0d: got %h expected ff", i, got_q[i]); end
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        tx_ready = 1'b0;
        fill_random(12);
        en = 1'b1;
        run_stim();
        checks++;
        if (tx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got valid=%b expected 1", tx_valid); end
        rst = 1'b1;
        step();
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || fault !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outs: got valid=%b data=%h fault=%b expected 0 00 0", tx_valid, tx_data, fault);
        end
        rst = 1'b0;
        got_q.delete();
        bit_q.delete();
        tx_ready = 1'b1;
        fill_random(8);
        run_stim();
        en = 1'b0;
        model_seg(1'b0);
        build_exp();
        wait_drain(1);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL rstmid_byte: got %0d bytes first=%h expected 1 byte %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]);
        end
    endtask

    task automatic test_vn_toggle();
        do_reset();
        tx_ready = 1'b1;
        vn_en = 1'b1;
        stim_q = '{0, 1, 1, 0, 0, 1, 1};
        en = 1'b1;
        run_stim();
        model_seg(1'b1);
        vn_en = 1'b0;
        step();
        vn_en = 1'b1;
        step();
        en = 1'b0;
        repeat (20) step();
        checks++;
        if (tx_valid !== 1'b0 || got_q.size() != 0) begin errors++; $display("FAIL vntog_idle: got valid=%b bytes=%0d expected 0 and 0", tx_valid, got_q.size()); end
        stim_q = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
        en = 1'b1;
        run_stim();
        en = 1'b0;
        model_seg(1'b1);
        build_exp();
        wait_drain(exp_q.size());
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL vntog_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL vntog_byte%0d: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; vn_en = 1'b0; rnd_in = 1'b0;
        fault_clr = 1'b0; tx_ready = 1'b0;
        test_reset();
        test_raw_latency();
        test_vn_pattern();
        test_random();
        test_stall();
        test_fault();
        test_rst_mid();
        test_vn_toggle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
